// File: rtl/qif_neuron_scheduler.sv
// Time-multiplexed quadratic integrate-and-fire scheduler for four neurons.
// Each tick runs one READ/WRITE pass per neuron. Spikes are queued in a
// first-word-fall-through FIFO as {neuron id, sweep count} events.
module qif_neuron_scheduler #(
  parameter int                 N_NEUR     = 4,
  parameter logic signed [7:0]  V_RESET    = -8'sd20,
  parameter logic signed [7:0]  V_PEAK     = 8'sd50,
  parameter int                 FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  output logic       busy_o,
  output logic       done_o,
  input  logic       cfg_we_i,
  input  logic       cfg_sel_i,
  input  logic [1:0] cfg_addr_i,
  input  logic [7:0] cfg_data_i,
  output logic       cfg_ready_o,
  input  logic [1:0] mon_addr_i,
  output logic [7:0] mon_v_o,
  output logic       spk_valid_o,
  input  logic       spk_ready_i,
  output logic [1:0] spk_id_o,
  output logic [7:0] spk_time_o,
  output logic       overrun_o,
  output logic       drop_o,
  input  logic       clr_err_i
);

  localparam int IW = 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_NEUR - 1);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state, state_nx;
  logic [IW-1:0]     idx;
  logic signed [7:0] v_mem [N_NEUR];
  logic signed [7:0] b_mem [N_NEUR];
  logic signed [7:0] v_r, b_r;
  logic [7:0]        tick_cnt;

  logic signed [7:0]  b_sh, v_new;
  logic signed [15:0] v_ext, sum;
  logic [15:0]        sq;
  logic               spike;

  logic [IW+7:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [PW:0]        count;
  logic               push, pop, full, push_ok, drop_set, cfg_ok;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nx    = state;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    cfg_ready_o = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready_o = 1'b1;
        if (tick_i) state_nx = READ;
      end
      READ: begin
        busy_o   = 1'b1;
        state_nx = WRITE;
      end
      WRITE: begin
        busy_o   = 1'b1;
        state_nx = (idx == LAST_IDX) ? DONE : READ;
      end
      DONE: begin
        busy_o   = 1'b1;
        done_o   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Neuron index: cleared on sweep start, advanced after each WRITE.
  always_ff @(posedge clk) begin
    if (!rst_n)                           idx <= '0;
    else if (state == IDLE && tick_i)     idx <= '0;
    else if (state == WRITE && idx != LAST_IDX) idx <= idx + 1'b1;
  end

  // QIF update. The square of a signed byte is at most 16384, so the 16-bit
  // product is exact and non-negative; the sum is formed at 16 bits before
  // clamping to the signed byte range.
  always_comb begin
    b_sh  = b_r >>> 2;
    v_ext = {{8{v_r[7]}}, v_r};
    sq    = v_ext * v_ext;
    sum   = v_ext + {{8{b_sh[7]}}, b_sh} + (sq >> 4);
    if (sum > 16'sd127)       v_new = 8'sd127;
    else if (sum < -16'sd128) v_new = -8'sd128;
    else                      v_new = sum[7:0];
    spike = (v_r >= V_PEAK);
  end

  // Operand latch for the neuron being processed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_r <= '0;
      b_r <= '0;
    end else if (state == READ) begin
      v_r <= v_mem[idx];
      b_r <= b_mem[idx];
    end
  end

  assign cfg_ok = cfg_we_i && (state == IDLE);

  // Neuron state storage: config writes in IDLE, membrane updates in WRITE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_NEUR; i++) begin
        v_mem[i] <= V_RESET;
        b_mem[i] <= '0;
      end
    end else begin
      if (cfg_ok) begin
        if (cfg_sel_i) v_mem[cfg_addr_i] <= cfg_data_i;
        else           b_mem[cfg_addr_i] <= cfg_data_i;
      end
      if (state == WRITE) v_mem[idx] <= spike ? V_RESET : v_new;
    end
  end

  // Sweep counter used as the spike timestamp.
  always_ff @(posedge clk) begin
    if (!rst_n)             tick_cnt <= '0;
    else if (state == DONE) tick_cnt <= tick_cnt + 8'd1;
  end

  assign push     = (state == WRITE) && spike;
  assign pop      = spk_valid_o && spk_ready_i;
  assign full     = (count == FULL_CNT);
  assign push_ok  = push && (!full || pop);
  assign drop_set = push && full && !pop;

  // Event FIFO storage (no reset needed; guarded by count).
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= {idx, tick_cnt};
  end

  // Event FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign spk_valid_o            = (count != '0);
  assign {spk_id_o, spk_time_o} = fifo_mem[rd_ptr];
  assign mon_v_o                = v_mem[mon_addr_i];

  // Sticky error flags; a new error outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_o <= 1'b0;
      drop_o    <= 1'b0;
    end else begin
      if (tick_i && busy_o) overrun_o <= 1'b1;
      else if (clr_err_i)   overrun_o <= 1'b0;
      if (drop_set)         drop_o <= 1'b1;
      else if (clr_err_i)   drop_o <= 1'b0;
    end
  end

endmodule
